// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo core. The reservation stations use the
// same ones.
//   - Default operand/result width (DATA_W) and station tag width (TAG_W).
//   - TAG_NONE: the tag value that means "no producer".
//   - R-type opcode encodings OP_ADD .. OP_MUL.
//   - Functional-unit FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } fu_state_t;

endpackage

// File: rtl/alu_r_comb.sv
// -----------------------------------------------------------------------------
// alu_r_comb
// Purely combinational R-type datapath: opcode, operand A, operand B -> result.
// Optional feature macro: FU_MUL_EN.
//   - Defined: opcode 111 returns the low DATA_W bits of the unsigned product.
//   - Undefined: no multiplier is built, and opcode 111 returns 0.
// Ports:
//   op  in  3       operation select (OP_* encodings)
//   a   in  DATA_W  operand A (Vj)
//   b   in  DATA_W  operand B (Vk); only b[3:0] is used for shifts
//   y   out DATA_W  result
// -----------------------------------------------------------------------------
module alu_r_comb #(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    import tomasulo_pkg::*;

    logic slt_bit;

    always_comb begin
        slt_bit = ($signed(a) < $signed(b));
        y       = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_SLT: y = {{(DATA_W-1){1'b0}}, slt_bit};
            OP_SLL: y = a << b[3:0];
            OP_SRL: y = a >> b[3:0];
`ifdef FU_MUL_EN
            OP_MUL: y = a * b;          // product truncated to its low DATA_W bits
`else
            OP_MUL: y = '0;             // zero result, still broadcast so dependants wake up
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/func_unit_r.sv
// -----------------------------------------------------------------------------
// func_unit_r
// R-type functional unit behind the R reservation station. It accepts one
// dispatched operation and runs it for that operation's latency. It then
// requests the CDB and broadcasts tag + result on grant.
// Optional feature macro: FU_MUL_EN (MUL with MUL_LAT latency; otherwise MUL
// finishes in 1 cycle with result 0).
// Ports:
//   Clock      in   1       rising-edge clock
//   Reset      in   1       asynchronous active-high reset
//   Start      in   1       dispatch strobe
//   Opcode     in   3       operation select
//   Vj, Vk     in   DATA_W  operands (Vk[3:0] is the shift amount)
//   Tag        in   TAG_W   issuing station id (0 = no producer, ignored)
//   Busy       out  1       unit occupied (EXEC or WB)
//   Cdb_req    out  1       CDB request, held until granted
//   Cdb_grant  in   1       arbiter grant
//   Cdb_valid  out  1       broadcast valid (Cdb_req & Cdb_grant)
//   Cdb_tag    out  TAG_W   broadcast tag, 0 unless Cdb_valid
//   Cdb_data   out  DATA_W  broadcast result, 0 unless Cdb_valid
// Handshake: a result is transferred on every cycle where Cdb_req and
// Cdb_grant are both high. Cdb_req never drops before that cycle, and a grant
// without a request is ignored.
// -----------------------------------------------------------------------------
module func_unit_r #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        Opcode,
    input  logic [DATA_W-1:0] Vj,
    input  logic [DATA_W-1:0] Vk,
    input  logic [TAG_W-1:0]  Tag,
    output logic              Busy,
    output logic              Cdb_req,
    input  logic              Cdb_grant,
    output logic              Cdb_valid,
    output logic [TAG_W-1:0]  Cdb_tag,
    output logic [DATA_W-1:0] Cdb_data
);
    import tomasulo_pkg::*;

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    fu_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  lat_m1;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] vj_r;
    logic [DATA_W-1:0] vk_r;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] result_r;
    logic [DATA_W-1:0] alu_y;
    logic              busy_r;
    logic              req_r;

    // Latency minus one for the incoming opcode. The counter counts down to 0.
    always_comb begin
        lat_m1 = '0;
        case (Opcode)
            OP_ADD, OP_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
`ifdef FU_MUL_EN
            OP_MUL:         lat_m1 = CNT_W'(MUL_LAT - 1);
`endif
            default:        lat_m1 = '0;
        endcase
    end

    // The datapath works only on the operands latched at acceptance.
    alu_r_comb #(.DATA_W(DATA_W)) u_alu (
        .op (op_r),
        .a  (vj_r),
        .b  (vk_r),
        .y  (alu_y)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_r     <= '0;
            vj_r     <= '0;
            vk_r     <= '0;
            tag_r    <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            req_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start && (Tag != TAG_W'(TAG_NONE))) begin
                        op_r   <= Opcode;
                        vj_r   <= Vj;
                        vk_r   <= Vk;
                        tag_r  <= Tag;
                        cnt    <= lat_m1;
                        busy_r <= 1'b1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        result_r <= alu_y;
                        req_r    <= 1'b1;
                        state    <= ST_WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    if (Cdb_grant) begin
                        req_r  <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    req_r  <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_r;
    assign Cdb_req   = req_r;
    assign Cdb_valid = req_r & Cdb_grant;
    // The bus lines stay quiet unless this unit actually owns the CDB.
    assign Cdb_tag   = Cdb_valid ? tag_r    : '0;
    assign Cdb_data  = Cdb_valid ? result_r : '0;

endmodule

// File: tb/tb_func_unit_r.sv
// -----------------------------------------------------------------------------
// tb_func_unit_r
// Directed bench for func_unit_r. It follows FU_MUL_EN for the MUL
// expectations. Inputs change 1 time unit after the rising edge. A negedge
// monitor checks every CDB broadcast against an expected queue.
// -----------------------------------------------------------------------------
module tb_func_unit_r;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;
`ifdef FU_MUL_EN
    localparam int MUL_EXP_LAT = 4;
`else
    localparam int MUL_EXP_LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  tag;
    logic              busy;
    logic              cdb_req;
    logic              cdb_grant;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bcast  = 0;

    logic [TAG_W+DATA_W-1:0] exp_q[$];
    logic [TAG_W+DATA_W-1:0] exp_ent;

    func_unit_r #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .ADD_LAT (2),
        .MUL_LAT (4)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .Start     (start),
        .Opcode    (opcode),
        .Vj        (vj),
        .Vk        (vk),
        .Tag       (tag),
        .Busy      (busy),
        .Cdb_req   (cdb_req),
        .Cdb_grant (cdb_grant),
        .Cdb_valid (cdb_valid),
        .Cdb_tag   (cdb_tag),
        .Cdb_data  (cdb_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every broadcast must match the oldest expected entry. While
    // no broadcast is made, the bus must read zero.
    always @(negedge clk) begin
        if (cdb_valid) begin
            n_bcast++;
            check_eq("bcast_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_ent = exp_q.pop_front();
                check_eq("cdb_tag", 32'(cdb_tag), 32'(exp_ent[TAG_W+DATA_W-1:DATA_W]));
                check_eq("cdb_data", 32'(cdb_data), 32'(exp_ent[DATA_W-1:0]));
            end
        end else begin
            check_eq("idle_cdb_tag", 32'(cdb_tag), 32'd0);
            check_eq("idle_cdb_data", 32'(cdb_data), 32'd0);
        end
    end

    // driver tasks
    task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] t);
        opcode = op;
        vj     = a;
        vk     = b;
        tag    = t;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges after the acceptance edge until Cdb_req is seen high.
    task automatic wait_req(input string name, input int exp_lat);
        int lat;
        lat = 0;
        while (!cdb_req && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({name, "_req_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Full operation with the grant already high: accept, wait, broadcast, idle.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] exp_data,
                          input int exp_lat);
        int b0;
        b0 = n_bcast;
        exp_q.push_back({t, exp_data});
        issue(op, a, b, t);
        check_eq({name, "_busy"}, 32'(busy), 32'd1);
        wait_req(name, exp_lat);
        check_eq({name, "_valid"}, 32'(cdb_valid), 32'd1);
        tick();
        check_eq({name, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_idle_req"}, 32'(cdb_req), 32'd0);
        check_eq({name, "_bcast_once"}, 32'(n_bcast - b0), 32'd1);
    endtask

    initial begin
        int b0;
        rst       = 1'b1;
        start     = 1'b0;
        opcode    = 3'b000;
        vj        = '0;
        vk        = '0;
        tag       = '0;
        cdb_grant = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req", 32'(cdb_req), 32'd0);
        check_eq("rst_valid", 32'(cdb_valid), 32'd0);
        check_eq("rst_tag", 32'(cdb_tag), 32'd0);
        check_eq("rst_data", 32'(cdb_data), 32'd0);
        rst = 1'b0;
        tick();

        // grant tied high, back-to-back operations
        cdb_grant = 1'b1;
        run_op("add",     3'b000, 16'h0005, 16'h0003, 3'd2, 16'h0008, 2);
        run_op("sub",     3'b001, 16'h0000, 16'h0001, 3'd1, 16'hFFFF, 2);
        run_op("slt_neg", 3'b100, 16'h8000, 16'h0001, 3'd4, 16'h0001, 1);
        run_op("slt_pos", 3'b100, 16'h0001, 16'h8000, 3'd4, 16'h0000, 1);
        run_op("srl",     3'b110, 16'h8000, 16'h0013, 3'd5, 16'h1000, 1);
        run_op("sll",     3'b101, 16'h0001, 16'h0024, 3'd6, 16'h0010, 1);
        run_op("or",      3'b011, 16'h00F0, 16'h0F00, 3'd7, 16'h0FF0, 1);
        run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0002, 3'd2, 16'h0001, 2);

        // grant withheld; a second Start while busy must be ignored
        cdb_grant = 1'b0;
        b0 = n_bcast;
        exp_q.push_back({3'd6, 16'h000F});
        issue(3'b010, 16'h0F0F, 16'h00FF, 3'd6);
        wait_req("and_hold", 1);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_req", 32'(cdb_req), 32'd1);
            check_eq("hold_valid", 32'(cdb_valid), 32'd0);
            if (i == 1) begin
                opcode = 3'b000;
                vj     = 16'h1111;
                vk     = 16'h2222;
                tag    = 3'd7;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
            end
            tick();
        end
        cdb_grant = 1'b1;
        #1;
        check_eq("hold_grant_valid", 32'(cdb_valid), 32'd1);
        check_eq("hold_grant_tag", 32'(cdb_tag), 32'd6);
        check_eq("hold_grant_data", 32'(cdb_data), 32'h000F);
        tick();
        check_eq("hold_done_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("hold_after_req", 32'(cdb_req), 32'd0);
            tick();
        end
        check_eq("hold_bcast_once", 32'(n_bcast - b0), 32'd1);

        // Tag 0 is not a producer and is never accepted
        issue(3'b000, 16'h0001, 16'h0001, 3'd0);
        check_eq("tag0_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_eq("tag0_req", 32'(cdb_req), 32'd0);
            tick();
        end

        // reset in EXEC discards the pending result
        b0 = n_bcast;
        issue(3'b000, 16'h0002, 16'h0002, 3'd3);
        check_eq("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy0", 32'(busy), 32'd0);
        check_eq("rst_mid_req0", 32'(cdb_req), 32'd0);
        check_eq("rst_mid_valid0", 32'(cdb_valid), 32'd0);
        check_eq("rst_mid_tag0", 32'(cdb_tag), 32'd0);
        check_eq("rst_mid_data0", 32'(cdb_data), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("rst_mid_no_req", 32'(cdb_req), 32'd0);
        end
        check_eq("rst_mid_no_bcast", 32'(n_bcast - b0), 32'd0);

        // MUL: the real product with FU_MUL_EN, otherwise a zero result after one cycle
`ifdef FU_MUL_EN
        run_op("mul_big",   3'b111, 16'h0100, 16'h0100, 3'd3, 16'h0000, MUL_EXP_LAT);
        run_op("mul_small", 3'b111, 16'h0003, 16'h0004, 3'd3, 16'h000C, MUL_EXP_LAT);
`else
        run_op("mul_big",   3'b111, 16'h0100, 16'h0100, 3'd3, 16'h0000, MUL_EXP_LAT);
        run_op("mul_small", 3'b111, 16'h0003, 16'h0004, 3'd3, 16'h0000, MUL_EXP_LAT);
`endif

        tick();
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
